// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: FSM states, RV32 load/store width codes and access-size helper for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: flags misaligned, illegal-width or out-of-range data-memory commands
module dmem_align_chk
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 2000
) (
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        err
);
  logic [32:0] last;
  logic bad_f3, bad_align, bad_range;
  always_comb begin
    last = {1'b0, addr} + {30'b0, f3_size(funct3)} - 33'd1;
    bad_f3 = we ? funct3 > F3_W : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    bad_align = (funct3 inside {F3_H, F3_HU}) ? addr[0] : funct3 == F3_W ? |addr[1:0] : 1'b0;
    bad_range = last >= 33'(MEM_BYTES);
    err = bad_f3 | bad_align | bad_range;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter that sequences each grant into one registered memory strobe and a response.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned, illegal-width and out-of-range commands.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 2000
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic        iWe0,
  input  logic        iWe1,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iAddr1,
  input  logic [31:0] iWdata0,
  input  logic [31:0] iWdata1,
  input  logic [2:0]  iFunct3_0,
  input  logic [2:0]  iFunct3_1,
  output logic        oGnt0,
  output logic        oGnt1,
  output logic        oRvalid0,
  output logic        oRvalid1,
  output logic [31:0] oRdata0,
  output logic [31:0] oRdata1,
  output logic        oErr0,
  output logic        oErr1,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  output logic [2:0]  oMemFunct3,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemReadData
);
  state_e state_q, state_d;
  logic prio_q, prio_d, sel_q, sel_d, we_q, we_d, rej_q, rej_d;
  logic [1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0] mem_f3_q, mem_f3_d;
  logic mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic win, c_we, c_rej;
  logic [31:0] c_addr, c_wdata;
  logic [2:0] c_f3;
  // Port 1 wins when alone or when it holds priority in a tie
  assign win = iReq1 & (~iReq0 | prio_q);
  assign c_we = win ? iWe1 : iWe0;
  assign c_addr = win ? iAddr1 : iAddr0;
  assign c_wdata = win ? iWdata1 : iWdata0;
  assign c_f3 = win ? iFunct3_1 : iFunct3_0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  dmem_align_chk #(.MEM_BYTES(MEM_BYTES)) u_chk (
    .we(c_we),
    .addr(c_addr),
    .funct3(c_f3),
    .err(c_rej)
  );
`else
  logic unused_mem_bytes;
  assign unused_mem_bytes = ^MEM_BYTES;
  assign c_rej = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    sel_d = sel_q;
    we_d = we_q;
    rej_d = rej_q;
    gnt_d = '0;
    rvalid_d = '0;
    err_d = '0;
    rdata_d = '0;
    mem_addr_d = '0;
    mem_wdata_d = '0;
    mem_f3_d = '0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    case (state_q)
      IDLE: if (iReq0 | iReq1) begin
        state_d = ACCESS;
        prio_d = (iReq0 & iReq1) ? ~win : prio_q;
        sel_d = win;
        we_d = c_we;
        rej_d = c_rej;
        gnt_d = win ? 2'b10 : 2'b01;
        mem_addr_d = c_addr;
        mem_wdata_d = c_wdata;
        mem_f3_d = c_f3;
        mem_we_d = c_we & ~c_rej;
        mem_re_d = ~c_we & ~c_rej;
      end
      ACCESS: begin
        state_d = RESP;
        rvalid_d = sel_q ? 2'b10 : 2'b01;
        err_d = {2{rej_q}} & rvalid_d;
        rdata_d[sel_q] = (we_q | rej_q) ? 32'h0 : iMemReadData;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      sel_q <= 1'b0;
      we_q <= 1'b0;
      rej_q <= 1'b0;
      gnt_q <= '0;
      rvalid_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_f3_q <= '0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      sel_q <= sel_d;
      we_q <= we_d;
      rej_q <= rej_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_f3_q <= mem_f3_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
    end
  end
  assign oGnt0 = gnt_q[0];
  assign oGnt1 = gnt_q[1];
  assign oRvalid0 = rvalid_q[0];
  assign oRvalid1 = rvalid_q[1];
  assign oErr0 = err_q[0];
  assign oErr1 = err_q[1];
  assign oRdata0 = rdata_q[0];
  assign oRdata1 = rdata_q[1];
  assign oMemAddress = mem_addr_q;
  assign oMemWriteData = mem_wdata_q;
  assign oMemFunct3 = mem_f3_q;
  assign oMemWrite = mem_we_q;
  assign oMemRead = mem_re_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory. It shares the single combinational data-memory port between the core load/store path (port 0) and the program-loader/debug path (port 1), using round-robin priority. Each winning request is converted into a one-cycle, registered, glitch-free read or write strobe, and a registered response is returned. It sits between the execute/memory stage and the data memory; the memory itself is unchanged.

## Interface
- MEM_BYTES, 2000: data-memory size in bytes; used by the range check.
- iClk  in  1  clock; all state changes on the rising edge.
- iRstN  in  1  synchronous, active-low reset.
- iReq0 / iReq1  in  1  request, held until granted.
- iWe0 / iWe1  in  1  1 = store, 0 = load.
- iAddr0 / iAddr1  in  32  byte address.
- iWdata0 / iWdata1  in  32  store data, LSB-aligned.
- iFunct3_0 / iFunct3_1  in  3  access width/sign, RV32 load/store encoding.
- oGnt0 / oGnt1  out  1  one-cycle grant pulse.
- oRvalid0 / oRvalid1  out  1  one-cycle completion pulse (loads and stores).
- oRdata0 / oRdata1  out  32  load result, valid with oRvalid.
- oErr0 / oErr1  out  1  access rejected, valid with oRvalid.
- oMemAddress  out  32  to memory iAddress.
- oMemWriteData  out  32  to memory iWriteData.
- oMemFunct3  out  3  to memory iFunct3.
- oMemWrite / oMemRead  out  1  memory strobes.
- iMemReadData  in  32  from memory oReadData (combinational).

## Operation
- States:
  - IDLE: waits for a request. If iReq0 or iReq1 is high, select the winner, latch that port's we/addr/wdata/funct3, and go to ACCESS.
  - ACCESS: lasts exactly 1 cycle, then goes to RESP.
  - RESP: lasts exactly 1 cycle, then goes to IDLE.
- Arbitration:
  - With one requester, that requester wins.
  - With both requesting, the port named by the rPrio register wins, and rPrio flips to the other port.
  - rPrio resets to 0.
- ACCESS cycle:
  - Drive oMemAddress, oMemWriteData and oMemFunct3 from the latched command.
  - Drive exactly one of oMemRead or oMemWrite high.
  - Capture iMemReadData on the closing edge.
- RESP cycle:
  - oRvalid of the winning port is high.
  - oRdata carries the captured data for loads and 0 for stores.
- All memory-side outputs are flops. Outside ACCESS, the strobes are 0 and address/data/funct3 are 0, so the combinational memory write path never sees glitches.
- iReq is ignored in ACCESS and RESP.
- A requester must drop iReq in its oGnt cycle. If iReq is still high in IDLE after RESP, it is treated as a new request.
- The non-winning request stays pending. It is granted in the IDLE cycle that follows RESP.

## Timing
- Request sampled in IDLE at cycle T:
  - oGnt high in T+1, the ACCESS cycle.
  - oRvalid high in T+2, the RESP cycle.
- Throughput: one access per 3 cycles.
- Back-to-back requests from both ports: grants 3 cycles apart, alternating ports.
- Reset:
  - Values: state=IDLE, rPrio=0, all oGnt/oRvalid/oErr/oMemRead/oMemWrite=0, all data/address outputs=0.
  - Reset asserted mid-ACCESS: the strobe drops at the next edge. No response is issued for the aborted access. A store may or may not have landed.
- oGnt0 and oGnt1 are never high together. The same holds for oRvalid0 and oRvalid1.

## Configuration
- DMEM_ARB_ALIGN_CHECK_EN defined — the check runs in IDLE on the winning command. The access is rejected when any of these holds:
  - halfword (001/101) with addr[0]≠0;
  - word (010) with addr[1:0]≠0;
  - load funct3 ∈ {011,110,111};
  - store funct3 > 010;
  - addr + size − 1 ≥ MEM_BYTES.
- Rejected access: ACCESS runs with both strobes 0, and in RESP oRvalid=1, oErr=1, oRdata=0.
- DMEM_ARB_ALIGN_CHECK_EN undefined: no check logic is built, oErr0/oErr1 are tied 0, and every command reaches the memory unchanged.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - a function mapping funct3 to access size in bytes.
- One sub-module, dmem_align_chk: combinational, takes we/addr/funct3 and returns err. It is instantiated only under DMEM_ARB_ALIGN_CHECK_EN.
- Arbitration, FSM, command latch and response registers live in dmem_arbiter.

## Test plan
- Port 0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10: oGnt0 at T+1, oMemWrite high for exactly 1 cycle, load oRvalid0 at T+2 with oRdata0=0xDEADBEEF.
- Port 1 sb 0x81 to 0x20, then lb and lbu 0x20: oRdata1=0xFFFFFF81 and 0x00000081 respectively.
- iReq0 and iReq1 held high together for 4 grants: grant order 0,1,0,1, grants spaced 3 cycles apart, never simultaneous.
- With the macro defined: lw 0x12 → oErr=1, oRdata=0, no strobe; sh 0x7CF with MEM_BYTES=2000 → oErr=1. With the macro undefined: the same lw reaches memory and oErr=0.
- iRstN low in the ACCESS cycle of a read: next cycle all outputs 0, state IDLE, no oRvalid. After release, the first request is granted to port 0.
- iReq0 left high through RESP: the request is re-served as a new access with a new oGnt0, confirming the hold-until-grant rule.
